approx_adder_error_monitor: RTL and testbench

//  Downstream checker for 16-bit approximate ripple-carry adders (IN1, IN2 -> 17-bit Out).

---
 rtl/approx_adder_error_monitor.sv | 162 ++++++++++++++++
 tb/tb_approx_adder_error_monitor.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_adder_error_monitor.sv
// rtl/approx_adder_error_monitor.sv - windowed error statistics for approximate adders (optional ERR_MON_SQERR_EN adds sum_sq)
module approx_adder_error_monitor #(
    parameter int W     = 16,
    parameter int LOG_N = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           IN1,
    input  logic [W-1:0]           IN2,
    input  logic [W:0]             approx_out,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [W+LOG_N:0]       sum_ed,
    output logic [LOG_N:0]         err_cnt,
    output logic [W:0]             max_ed,
`ifdef ERR_MON_SQERR_EN
    output logic [2*(W+1)+LOG_N-1:0] sum_sq,
`endif
    output logic                   busy
);

    localparam int EW    = W + 1;
    localparam int SUM_W = W + 1 + LOG_N;
    localparam int CNT_W = LOG_N + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG_N) - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_REPORT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              s1_valid_q, s1_valid_d;
    logic [EW-1:0]     s1_exact_q, s1_exact_d;
    logic [EW-1:0]     s1_approx_q, s1_approx_d;
    logic [SUM_W-1:0]  sum_ed_q, sum_ed_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [EW-1:0]     max_ed_q, max_ed_d;

    logic              accept;
    logic [EW-1:0]     exact_sum;
    logic [EW-1:0]     ed;

    assign accept    = in_valid && (state_q == ST_RUN);
    assign exact_sum = EW'(IN1) + EW'(IN2);
    // absolute error of the sample sitting in stage 1
    assign ed        = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                                   : (s1_approx_q - s1_exact_q);

`ifdef ERR_MON_SQERR_EN
    localparam int SQ_W  = 2 * EW;
    localparam int SSQ_W = SQ_W + LOG_N;
    logic [SQ_W-1:0]  ed_sq;
    logic [SSQ_W-1:0] sum_sq_q, sum_sq_d;
    assign ed_sq  = SQ_W'(ed) * SQ_W'(ed);
    assign sum_sq = sum_sq_q;
`endif

    // next-state: capture stage, accumulate stage, window control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s1_valid_d  = 1'b0;
        s1_exact_d  = s1_exact_q;
        s1_approx_d = s1_approx_q;
        sum_ed_d    = sum_ed_q;
        err_cnt_d   = err_cnt_q;
        max_ed_d    = max_ed_q;
`ifdef ERR_MON_SQERR_EN
        sum_sq_d    = sum_sq_q;
`endif
        if (accept) begin
            s1_valid_d  = 1'b1;
            s1_exact_d  = exact_sum;
            s1_approx_d = approx_out;
            cnt_d       = cnt_q + 1'b1;
        end
        if (s1_valid_q) begin
            sum_ed_d  = sum_ed_q + SUM_W'(ed);
            err_cnt_d = err_cnt_q + CNT_W'(ed != '0);
            if (ed > max_ed_q) begin
                max_ed_d = ed;
            end
`ifdef ERR_MON_SQERR_EN
            sum_sq_d  = sum_sq_q + SSQ_W'(ed_sq);
`endif
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    sum_ed_d  = '0;
                    err_cnt_d = '0;
                    max_ed_d  = '0;
`ifdef ERR_MON_SQERR_EN
                    sum_sq_d  = '0;
`endif
                end
            end
            ST_RUN: begin
                if (accept && (cnt_q == CNT_LAST)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state and pipeline registers with synchronous clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_exact_q  <= '0;
            s1_approx_q <= '0;
            sum_ed_q    <= '0;
            err_cnt_q   <= '0;
            max_ed_q    <= '0;
`ifdef ERR_MON_SQERR_EN
            sum_sq_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_exact_q  <= s1_exact_d;
            s1_approx_q <= s1_approx_d;
            sum_ed_q    <= sum_ed_d;
            err_cnt_q   <= err_cnt_d;
            max_ed_q    <= max_ed_d;
`ifdef ERR_MON_SQERR_EN
            sum_sq_q    <= sum_sq_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_RUN);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign res_valid = (state_q == ST_REPORT);
    assign sum_ed    = sum_ed_q;
    assign err_cnt   = err_cnt_q;
    assign max_ed    = max_ed_q;

endmodule

// File: tb/tb_approx_adder_error_monitor.sv
// tb/tb_approx_adder_error_monitor.sv - self-checking bench for approx_adder_error_monitor
module tb_approx_adder_error_monitor;

    localparam int W     = 16;
    localparam int LOG_N = 2;
    localparam int NS    = 1 << LOG_N;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     IN1;
    logic [W-1:0]     IN2;
    logic [W:0]       approx_out;
    logic             res_valid;
    logic             res_ready;
    logic [W+LOG_N:0] sum_ed;
    logic [LOG_N:0]   err_cnt;
    logic [W:0]       max_ed;
    logic             busy;
`ifdef ERR_MON_SQERR_EN
    logic [2*(W+1)+LOG_N-1:0] sum_sq;
`endif

    int vectors     = 0;
    int miscompares = 0;

    int     s_in1 [NS];
    int     s_in2 [NS];
    int     s_apx [NS];
    longint exp_sum;
    longint exp_sq;
    longint exp_cnt;
    longint exp_max;

    approx_adder_error_monitor #(.W(W), .LOG_N(LOG_N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .IN1        (IN1),
        .IN2        (IN2),
        .approx_out (approx_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .sum_ed     (sum_ed),
        .err_cnt    (err_cnt),
        .max_ed     (max_ed),
`ifdef ERR_MON_SQERR_EN
        .sum_sq     (sum_sq),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // reference statistics straight from the definition of error distance
    function automatic void compute_model();
        longint ex;
        longint d;
        exp_sum = 0; exp_sq = 0; exp_cnt = 0; exp_max = 0;
        for (int i = 0; i < NS; i++) begin
            ex = longint'(s_in1[i]) + longint'(s_in2[i]);
            d  = ex - longint'(s_apx[i]);
            if (d < 0) d = -d;
            exp_sum += d;
            exp_sq  += d * d;
            if (d != 0) exp_cnt++;
            if (d > exp_max) exp_max = d;
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        IN1 = '0; IN2 = '0; approx_out = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        vectors++;
        if ({res_valid, in_ready, busy} !== 3'b000 || sum_ed !== '0 || err_cnt !== '0 || max_ed !== '0) begin
            miscompares++;
            $display("FAIL reset: rv/rdy/busy=%b sum=%h cnt=%h max=%h, required all zero",
                     {res_valid, in_ready, busy}, sum_ed, err_cnt, max_ed);
        end
    endtask

    task automatic start_window(input string name);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || sum_ed !== '0 || err_cnt !== '0 || max_ed !== '0) begin
            miscompares++;
            $display("FAIL %s_start: busy=%b rdy=%b sum=%h cnt=%h max=%h, required busy=1 rdy=1 cleared",
                     name, busy, in_ready, sum_ed, err_cnt, max_ed);
        end
    endtask

    // feed the sample table (optionally with gaps / stray starts), then check latency and results
    task automatic run_window(input string name, input bit gaps, input bit stray_start);
        int acc = 0;
        int cyc = 0;
        int lat = 0;
        compute_model();
        start_window(name);
        while (acc < NS && cyc < 400) begin
            if (cyc > 0) @(negedge clk);
            in_valid   = !(gaps && ($urandom_range(0, 2) == 0));
            start      = stray_start ? 1'($urandom_range(0, 1)) : 1'b0;
            IN1        = 16'(s_in1[acc]);
            IN2        = 16'(s_in2[acc]);
            approx_out = 17'(s_apx[acc]);
            if (in_valid && in_ready) acc++;
            cyc++;
        end
        vectors++;
        if (acc != NS) begin
            miscompares++;
            $display("FAIL %s_feed: accepted %0d samples, required %0d", name, acc, NS);
        end
        start = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            IN1        = 16'($urandom);
            IN2        = 16'($urandom);
            approx_out = 17'($urandom);
            if (res_valid) lat = k;
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_drain_ready: in_ready=%b, required 0", name, in_ready);
            end
            if (k == 2) begin
                vectors++;
                if (longint'(sum_ed) != exp_sum || longint'(err_cnt) != exp_cnt) begin
                    miscompares++;
                    $display("FAIL %s_acc_latency: sum=%h cnt=%0d, required %h %0d",
                             name, sum_ed, err_cnt, exp_sum, exp_cnt);
                end
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (lat != 3) begin
            miscompares++;
            $display("FAIL %s_res_latency: res_valid after %0d cycles, required 3", name, lat);
        end
        vectors++;
        if (longint'(sum_ed) != exp_sum || longint'(err_cnt) != exp_cnt || longint'(max_ed) != exp_max) begin
            miscompares++;
            $display("FAIL %s_results: sum=%h cnt=%0d max=%h, required %h %0d %h",
                     name, sum_ed, err_cnt, max_ed, exp_sum, exp_cnt, exp_max);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_report_busy: busy=%b, required 0", name, busy);
        end
`ifdef ERR_MON_SQERR_EN
        vectors++;
        if (longint'(sum_sq) != exp_sq) begin
            miscompares++;
            $display("FAIL %s_sum_sq: got %h, required %h", name, sum_sq, exp_sq);
        end
`endif
    endtask

    task automatic handshake(input string name);
        @(negedge clk);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        vectors++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || longint'(sum_ed) != exp_sum || longint'(max_ed) != exp_max) begin
            miscompares++;
            $display("FAIL %s_handshake: rv=%b busy=%b sum=%h max=%h, required rv=0 busy=0 sum=%h max=%h",
                     name, res_valid, busy, sum_ed, max_ed, exp_sum, exp_max);
        end
    endtask

    task automatic test_scenario1();
        s_in1 = '{0, 1, 0, 3};
        s_in2 = '{0, 0, 1, 3};
        s_apx = '{0, 1, 2, 6};
        run_window("scn1", 1'b0, 1'b0);
        vectors++;
        if (sum_ed !== 19'h1 || err_cnt !== 3'd1 || max_ed !== 17'h1) begin
            miscompares++;
            $display("FAIL scn1_fixed: sum=%h cnt=%0d max=%h, required 1 1 1", sum_ed, err_cnt, max_ed);
        end
        handshake("scn1");
    endtask

    task automatic test_scenario2();
        s_in1 = '{'hFFFF, 'hFFFF, 0, 'h8000};
        s_in2 = '{'hFFFF, 1, 0, 'h8000};
        s_apx = '{0, 'h10000, 'h1FFFF, 0};
        run_window("scn2", 1'b0, 1'b0);
        vectors++;
        if (sum_ed !== 19'h4FFFD || err_cnt !== 3'd3 || max_ed !== 17'h1FFFF) begin
            miscompares++;
            $display("FAIL scn2_fixed: sum=%h cnt=%0d max=%h, required 4FFFD 3 1FFFF", sum_ed, err_cnt, max_ed);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            res_ready  = 1'b0;
            in_valid   = 1'b1;
            start      = 1'($urandom_range(0, 1));
            IN1        = 16'($urandom);
            IN2        = 16'($urandom);
            approx_out = 17'($urandom);
            vectors++;
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || longint'(sum_ed) != exp_sum ||
                longint'(err_cnt) != exp_cnt || longint'(max_ed) != exp_max) begin
                miscompares++;
                $display("FAIL hold_%0d: rv=%b rdy=%b sum=%h cnt=%0d max=%h, required held results",
                         i, res_valid, in_ready, sum_ed, err_cnt, max_ed);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        start     = 1'b0;
        vectors++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release: rv=%b busy=%b rdy=%b, required 0 0 0", res_valid, busy, in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            IN1        = 16'($urandom);
            approx_out = 17'($urandom);
            vectors++;
            if (busy !== 1'b0 || in_ready !== 1'b0 || longint'(sum_ed) != exp_sum || longint'(max_ed) != exp_max) begin
                miscompares++;
                $display("FAIL idle_ignore_%0d: busy=%b rdy=%b sum=%h max=%h, required idle and held",
                         i, busy, in_ready, sum_ed, max_ed);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_midwindow();
        start_window("midrst");
        for (int i = 0; i < 2; i++) begin
            in_valid   = 1'b1;
            IN1        = 16'h1234;
            IN2        = 16'h0F00;
            approx_out = 17'h00007;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if ({res_valid, in_ready, busy} !== 3'b000 || sum_ed !== '0 || err_cnt !== '0 || max_ed !== '0) begin
            miscompares++;
            $display("FAIL midrst_clear: rv/rdy/busy=%b sum=%h cnt=%h max=%h, required zero",
                     {res_valid, in_ready, busy}, sum_ed, err_cnt, max_ed);
        end
        for (int i = 0; i < NS; i++) begin
            s_in1[i] = int'($urandom_range(0, 65535));
            s_in2[i] = int'($urandom_range(0, 65535));
            s_apx[i] = s_in1[i] + s_in2[i];
        end
        run_window("midrst_zero", 1'b0, 1'b0);
        handshake("midrst_zero");
    endtask

    task automatic test_random();
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < NS; i++) begin
                s_in1[i] = int'($urandom_range(0, 65535));
                s_in2[i] = int'($urandom_range(0, 65535));
                case ($urandom_range(0, 2))
                    0: s_apx[i] = s_in1[i] + s_in2[i];
                    1: s_apx[i] = (s_in1[i] + s_in2[i]) ^ int'($urandom_range(1, 255));
                    default: s_apx[i] = int'($urandom_range(0, 131071));
                endcase
            end
            run_window($sformatf("rand%0d", w), 1'b1, 1'b1);
            handshake($sformatf("rand%0d", w));
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_scenario1();
        test_scenario2();
        test_hold();
        test_reset_midwindow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
